// File: rtl/native_axi_bridge_pkg.sv
// Shared constants and state encoding for the native-to-AXI4 single-beat bridge.
package native_axi_bridge_pkg;

    localparam int NATIVE_ADDR_W = 32;
    localparam int NATIVE_DATA_W = 32;
    localparam int NATIVE_STRB_W = NATIVE_DATA_W / 8;
    localparam int DDR_ADDR_W    = 30;
    localparam int WORD_OFS      = 2;

    localparam logic [7:0] LEN_SINGLE    = 8'd0;
    localparam logic [2:0] SIZE_4B       = 3'b010;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] PROT_DEFAULT  = 3'b000;
    localparam logic [3:0] QOS_DEFAULT   = 4'b0000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_WB   = 3'd2,
        ST_RD   = 3'd3,
        ST_RR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/native_axi_bridge.sv
// Native slave port to single-beat AXI4 master, one transaction outstanding.
// resp_ready pulses 3 cycles after accept with zero AXI wait states; each wait state adds one.
module native_axi_bridge
    import native_axi_bridge_pkg::*;
#(
    parameter int ADDR_W     = NATIVE_ADDR_W,
    parameter int AXI_ADDR_W = DDR_ADDR_W,
    parameter int DATA_W     = NATIVE_DATA_W,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_ready,
    output logic                  resp_err,

    output logic                  m_axi_awid,
    output logic [AXI_ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic                  m_axi_arid,
    output logic [AXI_ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int STRB_W = DATA_W / 8;

    state_t                         state_q, state_d;
    logic                           aw_vld_q, aw_vld_d;
    logic                           w_vld_q, w_vld_d;
    logic                           b_rdy_q, b_rdy_d;
    logic                           ar_vld_q, ar_vld_d;
    logic                           r_rdy_q, r_rdy_d;
    logic                           err_q, err_d;
    logic [DATA_W-1:0]              rdata_q, rdata_d;
    logic [AXI_ADDR_W-1:WORD_OFS]   addr_q, addr_d;
    logic [DATA_W-1:0]              wdata_q, wdata_d;
    logic [STRB_W-1:0]              wstrb_q, wstrb_d;
    logic                           aw_done, w_done;

    // Byte offset, upper address bits, rlast and the low resp bit carry no meaning here.
    logic unused_in;
    assign unused_in = ^{req_addr, m_axi_bresp[0], m_axi_rresp[0], m_axi_rlast};

    // A channel counts as done once its valid has dropped or is handshaking this cycle.
    assign aw_done = !aw_vld_q || m_axi_awready;
    assign w_done  = !w_vld_q  || m_axi_wready;

    always_comb begin
        state_d  = state_q;
        aw_vld_d = aw_vld_q;
        w_vld_d  = w_vld_q;
        b_rdy_d  = b_rdy_q;
        ar_vld_d = ar_vld_q;
        r_rdy_d  = r_rdy_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[AXI_ADDR_W-1:WORD_OFS];
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    err_d   = 1'b0;
                    if (|req_wstrb) begin
                        aw_vld_d = 1'b1;
                        w_vld_d  = 1'b1;
                        state_d  = ST_WR;
                    end else begin
                        ar_vld_d = 1'b1;
                        state_d  = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (aw_vld_q && m_axi_awready) aw_vld_d = 1'b0;
                if (w_vld_q && m_axi_wready)   w_vld_d  = 1'b0;
                if (aw_done && w_done) begin
                    b_rdy_d = 1'b1;
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                if (m_axi_bvalid) begin
                    b_rdy_d = 1'b0;
                    err_d   = resp_is_err(m_axi_bresp);
                    state_d = ST_DONE;
                end
            end
            ST_RD: begin
                if (m_axi_arready) begin
                    ar_vld_d = 1'b0;
                    r_rdy_d  = 1'b1;
                    state_d  = ST_RR;
                end
            end
            ST_RR: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    r_rdy_d = 1'b0;
                    err_d   = resp_is_err(m_axi_rresp);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            aw_vld_q <= 1'b0;
            w_vld_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
            ar_vld_q <= 1'b0;
            r_rdy_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            aw_vld_q <= aw_vld_d;
            w_vld_q  <= w_vld_d;
            b_rdy_q  <= b_rdy_d;
            ar_vld_q <= ar_vld_d;
            r_rdy_q  <= r_rdy_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    assign resp_ready = (state_q == ST_DONE);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;

    assign m_axi_awid    = 1'(AXI_ID);
    assign m_axi_awaddr  = {addr_q, 2'b00};
    assign m_axi_awlen   = LEN_SINGLE;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_DEFAULT;
    assign m_axi_awprot  = PROT_DEFAULT;
    assign m_axi_awqos   = QOS_DEFAULT;
    assign m_axi_awvalid = aw_vld_q;

    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = w_vld_q;
    assign m_axi_bready  = b_rdy_q;

    assign m_axi_arid    = 1'(AXI_ID);
    assign m_axi_araddr  = {addr_q, 2'b00};
    assign m_axi_arlen   = LEN_SINGLE;
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = CACHE_DEFAULT;
    assign m_axi_arprot  = PROT_DEFAULT;
    assign m_axi_arqos   = QOS_DEFAULT;
    assign m_axi_arvalid = ar_vld_q;
    assign m_axi_rready  = r_rdy_q;

endmodule

// File: tb/tb_native_axi_bridge.sv
// Directed bench for native_axi_bridge with a delay-programmable AXI slave model.
module tb_native_axi_bridge;
    import native_axi_bridge_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [31:0] resp_rdata;
    logic        resp_ready, resp_err;

    logic        m_axi_awid, m_axi_awlock, m_axi_awvalid, m_axi_awready;
    logic [29:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst;
    logic [3:0]  m_axi_awcache, m_axi_awqos;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_arid, m_axi_arlock, m_axi_arvalid, m_axi_arready;
    logic [29:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize, m_axi_arprot;
    logic [1:0]  m_axi_arburst;
    logic [3:0]  m_axi_arcache, m_axi_arqos;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    native_axi_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_rdata(resp_rdata), .resp_ready(resp_ready), .resp_err(resp_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // Slave model: each ready/valid response waits *_dly cycles after the request side rises.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
    logic [31:0] rdata_v = '0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, viol = 0;
    logic [29:0] last_awaddr = '0, last_araddr = '0, prev_awaddr = '0;
    logic [31:0] last_wdata = '0, prev_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic        prev_aw_wait = 1'b0, prev_w_wait = 1'b0;

    assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
    assign m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_dly);
    assign m_axi_bvalid  = m_axi_bready  && (b_cnt  >= b_dly);
    assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
    assign m_axi_rvalid  = m_axi_rready  && (r_cnt  >= r_dly);
    assign m_axi_bresp   = bresp_v;
    assign m_axi_rresp   = rresp_v;
    assign m_axi_rdata   = rdata_v;
    assign m_axi_rlast   = 1'b1;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            prev_aw_wait <= 1'b0; prev_w_wait <= 1'b0;
        end else begin
            aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_axi_wvalid  && !m_axi_wready)  ? w_cnt + 1  : 0;
            b_cnt  <= (m_axi_bready  && !m_axi_bvalid)  ? b_cnt + 1  : 0;
            ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            r_cnt  <= (m_axi_rready  && !m_axi_rvalid)  ? r_cnt + 1  : 0;
            if (m_axi_awvalid && m_axi_awready) begin aw_hs <= aw_hs + 1; last_awaddr <= m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin
                w_hs <= w_hs + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb;
            end
            if (m_axi_bvalid && m_axi_bready)   b_hs <= b_hs + 1;
            if (m_axi_arvalid && m_axi_arready) begin ar_hs <= ar_hs + 1; last_araddr <= m_axi_araddr; end
            if (m_axi_rvalid && m_axi_rready)   r_hs <= r_hs + 1;
            // Protocol rules: a pending valid holds with stable payload; B waits for AW and W.
            if (prev_aw_wait && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) viol <= viol + 1;
            if (prev_w_wait && (!m_axi_wvalid || m_axi_wdata != prev_wdata))     viol <= viol + 1;
            if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid))                viol <= viol + 1;
            prev_aw_wait <= m_axi_awvalid && !m_axi_awready;
            prev_w_wait  <= m_axi_wvalid && !m_axi_wready;
            prev_awaddr  <= m_axi_awaddr;
            prev_wdata   <= m_axi_wdata;
        end
    end

    int errors = 0, checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        int          lat;
        logic        err;
        logic [31:0] exp_rdata;
        logic [29:0] exp_axaddr;
    } vec_t;

    vec_t vecs[8];

    task automatic run_txn(input int i);
        vec_t v;
        int   aw0, w0, b0, ar0, r0, lat;
        bit   got;
        logic [31:0] rd;
        logic        er;
        v = vecs[i];
        aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
        bresp_v = v.bresp; rresp_v = v.rresp; rdata_v = v.rdata;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        @(negedge clk);
        req_valid = 1'b1; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        lat = 0; got = 1'b0; rd = '0; er = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            if (resp_ready) begin got = 1'b1; rd = resp_rdata; er = resp_err; end
        end
        req_valid = 1'b0; req_wstrb = '0;
        if (!got) begin
            chk($sformatf("v%0d timeout", i), 32'd0, 32'd1);
        end else begin
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
            chk($sformatf("v%0d resp_err", i), {31'd0, er}, {31'd0, v.err});
            chk($sformatf("v%0d resp_rdata", i), rd, v.exp_rdata);
            if (v.wstrb != 4'd0) begin
                chk($sformatf("v%0d aw count", i), 32'(aw_hs - aw0), 32'd1);
                chk($sformatf("v%0d w count", i), 32'(w_hs - w0), 32'd1);
                chk($sformatf("v%0d b count", i), 32'(b_hs - b0), 32'd1);
                chk($sformatf("v%0d awaddr", i), {2'b00, last_awaddr}, {2'b00, v.exp_axaddr});
                chk($sformatf("v%0d wdata", i), last_wdata, v.wdata);
                chk($sformatf("v%0d wstrb", i), {28'd0, last_wstrb}, {28'd0, v.wstrb});
            end else begin
                chk($sformatf("v%0d ar count", i), 32'(ar_hs - ar0), 32'd1);
                chk($sformatf("v%0d r count", i), 32'(r_hs - r0), 32'd1);
                chk($sformatf("v%0d araddr", i), {2'b00, last_araddr}, {2'b00, v.exp_axaddr});
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d resp_ready pulse", i), {31'd0, resp_ready}, 32'd0);
        end
    endtask

    initial begin
        int ar0, b0, pulses, last_rr, gaps;
        bit prev_arv, in_wb;

        //          addr          wdata         strb  aw w  b  ar r  bresp  rresp  rdata         lat err exp_rdata     axaddr
        vecs[0] = '{32'h0000_1004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        3, 0, 32'h0,        30'h0000_1004};
        vecs[1] = '{32'hC000_2013, 32'h0102_0304, 4'h3, 4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,        7, 0, 32'h0,        30'h0000_2010};
        vecs[2] = '{32'h0000_0100, 32'h0,        4'h0, 0, 0, 0, 2, 5, 2'b00, 2'b00, 32'h1234_5678, 10, 0, 32'h1234_5678, 30'h0000_0100};
        vecs[3] = '{32'h0000_0040, 32'hFFFF_0000, 4'h8, 0, 0, 0, 0, 0, 2'b10, 2'b00, 32'h0,        3, 1, 32'h1234_5678, 30'h0000_0040};
        vecs[4] = '{32'hFFFF_FF47, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'hCAFE_F00D, 3, 1, 32'hCAFE_F00D, 30'h3FFF_FF44};
        vecs[5] = '{32'h0000_0048, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BAD_F00D, 3, 0, 32'h0BAD_F00D, 30'h0000_0048};
        vecs[6] = '{32'h0000_ABCE, 32'h7777_8888, 4'h6, 0, 2, 1, 0, 0, 2'b00, 2'b00, 32'h0,        6, 0, 32'h0BAD_F00D, 30'h0000_ABCC};
        vecs[7] = '{32'h0000_0200, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hA5A5_0001, 3, 0, 32'hA5A5_0001, 30'h0000_0200};

        repeat (3) @(posedge clk);
        #1;
        chk("reset valids/readies", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
        chk("reset resp_ready/err", {30'd0, resp_ready, resp_err}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("const aw sideband", {m_axi_awlen, 1'b0, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache,
                                  m_axi_awprot, m_axi_awqos, m_axi_awid, m_axi_wlast, 4'd0},
                                 {8'd0, 1'b0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0, 1'b1, 4'd0});
        chk("const ar sideband", {m_axi_arlen, 1'b0, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
                                  m_axi_arprot, m_axi_arqos, m_axi_arid, 5'd0},
                                 {8'd0, 1'b0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0, 5'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(i);

        // Three reads with req_valid held throughout.
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        rresp_v = 2'b00; rdata_v = 32'h55AA_55AA;
        ar0 = ar_hs; pulses = 0; last_rr = -1; gaps = 0; prev_arv = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0300; req_wstrb = 4'h0;
        for (int c = 1; c <= 40 && pulses < 3; c++) begin
            @(posedge clk); #1;
            if (m_axi_arvalid && !prev_arv && last_rr >= 0) begin
                gaps++;
                chk("b2b resp_ready to arvalid gap", 32'(c - last_rr), 32'd2);
            end
            if (resp_ready) begin pulses++; last_rr = c; end
            prev_arv = m_axi_arvalid;
        end
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b completions", 32'(pulses), 32'd3);
        chk("b2b gaps seen", 32'(gaps), 32'd2);
        chk("b2b ar handshakes", 32'(ar_hs - ar0), 32'd3);
        chk("b2b rdata", resp_rdata, 32'h55AA_55AA);

        // Reset while waiting for the write response.
        b_dly = 20; bresp_v = 2'b00; b0 = b_hs; in_wb = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0080; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
        for (int c = 0; c < 20 && !in_wb; c++) begin
            @(posedge clk); #1;
            if (m_axi_bready) in_wb = 1'b1;
        end
        chk("reset test reached WB", {31'd0, in_wb}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0; req_wstrb = 4'h0;
        @(posedge clk); #1;
        chk("mid-reset valids/readies", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
        chk("mid-reset resp_ready/err", {30'd0, resp_ready, resp_err}, 32'd0);
        chk("mid-reset resp_rdata", resp_rdata, 32'd0);
        chk("mid-reset state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1; b_dly = 0;
        @(posedge clk); #1;
        chk("post-reset no resp_ready", {31'd0, resp_ready}, 32'd0);
        chk("post-reset no B handshake", 32'(b_hs - b0), 32'd0);

        run_txn(7);

        chk("protocol violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
